// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue
//   Fetch-stage prefetch unit. It issues sequential word fetches to a
//   variable-latency instruction memory (req/gnt handshake, in-order rvalid).
//   Returned words are buffered with their PCs in a DEPTH-entry FIFO, and
//   decode pops the head through valid/ready. A taken branch from EX flushes
//   the FIFO, drops responses that are still in flight, and restarts fetching
//   at the branch target.
//
// Parameters
//   DEPTH     FIFO entries plus requests in flight combined (power of 2, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   redirect_i        taken branch/jump from EX
//   redirect_pc_i     redirect target
//   imem_req_o        fetch request valid
//   imem_addr_o       fetch word address
//   imem_gnt_i        request accepted this cycle
//   imem_rvalid_i     response valid (in request order)
//   imem_rdata_i      response instruction word
//   inst_valid_o      FIFO head valid
//   inst_o            head instruction (NOP 32'h0000_0013 when empty)
//   inst_pc_o         head PC (0 when empty)
//   inst_ready_i      decode accepts head
//   count_o           entries held
//
// Optional feature
//   PFQ_BYPASS_EN: when the FIFO is empty, nothing is being dropped and no
//   redirect is present, an arriving response is presented combinationally
//   on inst_*. If decode takes it in that cycle, it is not written into the
//   FIFO.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  output logic                     imem_req_o,
  output logic [31:0]              imem_addr_o,
  input  logic                     imem_gnt_i,
  input  logic                     imem_rvalid_i,
  input  logic [31:0]              imem_rdata_i,
  output logic                     inst_valid_o,
  output logic [31:0]              inst_o,
  output logic [31:0]              inst_pc_o,
  input  logic                     inst_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {RST_S = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     inst_mem_q [DEPTH];
  logic [31:0]     pc_mem_q   [DEPTH];

  logic            dropping;
  logic            fire;
  logic            fifo_empty;
  logic            accept;
  logic            push;
  logic            pop;
  logic            byp_valid;
  logic            byp_taken;
  logic [CW-1:0]   stale_cnt;

  // Requests still in flight after this cycle's response (if any) returns.
  assign stale_cnt  = out_q - CW'(imem_rvalid_i);
  assign fifo_empty = (count_q == '0);
  assign fire       = imem_req_o & imem_gnt_i;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RST_S;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RST_S: state_d = FETCH;
      FETCH: if (redirect_i && (stale_cnt != '0)) state_d = DRAIN;
      DRAIN: begin
        if (redirect_i)              state_d = (stale_cnt != '0) ? DRAIN : FETCH;
        else if (drop_cnt_d == '0)   state_d = FETCH;
      end
      default: state_d = RST_S;
    endcase
  end

  // FSM: outputs. DRAIN holds exactly while drop_cnt is non-zero.
  // No credit is taken for a same-cycle pop, keeping the request path
  // independent of inst_ready_i.
  always_comb begin
    dropping   = (state_q == DRAIN);
    imem_req_o = (state_q != RST_S) && !redirect_i &&
                 (({1'b0, count_q} + {1'b0, out_q}) < DEPTH_L);
  end

`ifdef PFQ_BYPASS_EN
  assign byp_valid = fifo_empty & !dropping & !redirect_i & imem_rvalid_i;
  assign byp_taken = byp_valid & inst_ready_i;
`else
  assign byp_valid = 1'b0;
  assign byp_taken = 1'b0;
`endif

  assign accept = imem_rvalid_i & !dropping & !redirect_i;
  assign push   = accept & !byp_taken;
  assign pop    = !fifo_empty & inst_ready_i & !redirect_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q + CW'(fire) - CW'(imem_rvalid_i);
    drop_cnt_d = drop_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    if (fire)                       fetch_pc_d = fetch_pc_q + 32'd4;
    if (accept)                     resp_pc_d  = resp_pc_q + 32'd4;
    if (imem_rvalid_i && dropping)  drop_cnt_d = drop_cnt_q - 1'b1;
    if (push)                       wr_ptr_d   = wr_ptr_q + 1'b1;
    if (pop)                        rd_ptr_d   = rd_ptr_q + 1'b1;
    // Redirect overrides everything: flush, and everything still in flight
    // becomes stale (fire and push are already blocked this cycle).
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i;
      resp_pc_d  = redirect_pc_i;
      drop_cnt_d = stale_cnt;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_cnt_q <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_cnt_q <= drop_cnt_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset; count_q alone qualifies the contents.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= imem_rdata_i;
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

  always_comb begin
    inst_valid_o = !fifo_empty | byp_valid;
    inst_o       = NOP;
    inst_pc_o    = '0;
    if (!fifo_empty) begin
      inst_o    = inst_mem_q[rd_ptr_q];
      inst_pc_o = pc_mem_q[rd_ptr_q];
    end else if (byp_valid) begin
      inst_o    = imem_rdata_i;
      inst_pc_o = resp_pc_q;
    end
  end

  assign imem_addr_o = fetch_pc_q;
  assign count_o     = count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (({1'b0, count_q} + {1'b0, out_q}) <= DEPTH_L);
      assert (drop_cnt_q <= out_q);
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Testbench for instr_prefetch_queue (default build).
// The bench acts as the instruction memory. It keeps a queue-based
// reference model and also runs a table of fixed vectors and several
// hand-written corner-case sequences.
module tb_instr_prefetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   redirect_i = 1'b0;
  logic [31:0]            redirect_pc_i = '0;
  logic                   imem_req_o;
  logic [31:0]            imem_addr_o;
  logic                   imem_gnt_i = 1'b0;
  logic                   imem_rvalid_i = 1'b0;
  logic [31:0]            imem_rdata_i = '0;
  logic                   inst_valid_o;
  logic [31:0]            inst_o;
  logic [31:0]            inst_pc_o;
  logic                   inst_ready_i = 1'b0;
  logic [$clog2(DEPTH):0] count_o;

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_ready_i(inst_ready_i), .count_o(count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'hC0DE_0001;
  endfunction

  // Reference model: in-flight request list and delivered-instruction FIFO
  typedef struct { logic [31:0] pc; bit stale; int unsigned gcyc; } infl_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  infl_t       infl[$];
  ent_t        fifo[$];
  logic [31:0] m_fetch_pc = RESET_PC;
  bit          m_started  = 0;
  int unsigned cyc        = 0;

  function automatic bit exp_req();
    return m_started && !redirect_i && ((fifo.size() + infl.size()) < DEPTH);
  endfunction

  task automatic check_outputs();
    bit v;
    v = (fifo.size() > 0);
    chk("req",   imem_req_o,   exp_req());
    chk("addr",  imem_addr_o,  m_fetch_pc);
    chk("valid", inst_valid_o, v);
    chk("inst",  inst_o,       v ? fifo[0].inst : NOP);
    chk("pc",    inst_pc_o,    v ? fifo[0].pc : 32'h0);
    chk("count", count_o,      fifo.size());
  endtask

  // Drive one cycle's inputs mid-cycle, then check the settled outputs.
  task automatic cyc_begin(input bit redir, input logic [31:0] rpc, input bit gnt,
                           input bit want_rv, input bit rdy);
    @(negedge clk);
    redirect_i    = redir;
    redirect_pc_i = rpc;
    imem_gnt_i    = gnt;
    inst_ready_i  = rdy;
    if (want_rv && infl.size() > 0 && infl[0].gcyc < cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(infl[0].pc);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    #1;
    check_outputs();
  endtask

  // Advance the model across the coming rising edge.
  task automatic cyc_end();
    bit    req, pop;
    infl_t e;
    req = exp_req();
    pop = (fifo.size() > 0) && inst_ready_i && !redirect_i;
    if (pop) void'(fifo.pop_front());
    if (imem_rvalid_i) begin
      e = infl.pop_front();
      if (!e.stale && !redirect_i) fifo.push_back('{inst: imem_rdata_i, pc: e.pc});
    end
    if (redirect_i) begin
      fifo.delete();
      foreach (infl[i]) infl[i].stale = 1'b1;
      m_fetch_pc = redirect_pc_i;
    end
    if (req && imem_gnt_i) begin
      infl.push_back('{pc: m_fetch_pc, stale: 1'b0, gcyc: cyc});
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    m_started = 1;
    cyc++;
  endtask

  task automatic step(input bit redir, input logic [31:0] rpc, input bit gnt,
                      input bit want_rv, input bit rdy);
    cyc_begin(redir, rpc, gnt, want_rv, rdy);
    cyc_end();
  endtask

  // Asserts reset mid-cycle; the outputs must reach reset values at once.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; inst_ready_i = 1'b0;
    #1;
    chk("rst_req",   imem_req_o,   1'b0);
    chk("rst_addr",  imem_addr_o,  RESET_PC);
    chk("rst_valid", inst_valid_o, 1'b0);
    chk("rst_inst",  inst_o,       NOP);
    chk("rst_pc",    inst_pc_o,    32'h0);
    chk("rst_count", count_o,      32'h0);
    fifo.delete();
    infl.delete();
    m_fetch_pc = RESET_PC;
    m_started  = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    bit          rv;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
    int unsigned e_cnt;
  } vec_t;

  vec_t        tbl[8];
  logic [31:0] first_pc;
  logic [31:0] pcs[3];
  int unsigned grants, gaps, n;
  bit          got;

  initial begin
    // gnt=1, response one cycle after grant, ready=1
    tbl[0] = '{0, 0, 32'h00, 0, 32'h00, 0};
    tbl[1] = '{0, 1, 32'h00, 0, 32'h00, 0};
    tbl[2] = '{1, 1, 32'h04, 0, 32'h00, 0};
    tbl[3] = '{1, 1, 32'h08, 1, 32'h00, 1};
    tbl[4] = '{1, 1, 32'h0C, 1, 32'h04, 1};
    tbl[5] = '{1, 1, 32'h10, 1, 32'h08, 1};
    tbl[6] = '{1, 1, 32'h14, 1, 32'h0C, 1};
    tbl[7] = '{1, 1, 32'h18, 1, 32'h10, 1};

    // Streaming from reset
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc_begin(0, 32'h0, 1, tbl[i].rv, 1);
      chk("t1_req",   imem_req_o,   tbl[i].e_req);
      chk("t1_addr",  imem_addr_o,  tbl[i].e_addr);
      chk("t1_valid", inst_valid_o, tbl[i].e_valid);
      chk("t1_pc",    inst_pc_o,    tbl[i].e_pc);
      chk("t1_inst",  inst_o,       tbl[i].e_valid ? mem_word(tbl[i].e_pc) : NOP);
      chk("t1_count", count_o,      tbl[i].e_cnt);
      cyc_end();
    end
    gaps = 0;
    repeat (20) begin
      cyc_begin(0, 32'h0, 1, 1, 1);
      if (!inst_valid_o) gaps++;
      cyc_end();
    end
    chk("t1_nogap", gaps, 32'h0);

    // Decode stalled: the credit limit caps grants at DEPTH
    do_reset();
    step(0, 32'h0, 1, 1, 0);
    grants = 0;
    repeat (20) begin
      cyc_begin(0, 32'h0, 1, 1, 0);
      if (imem_req_o && imem_gnt_i) grants++;
      cyc_end();
    end
    cyc_begin(0, 32'h0, 1, 1, 0);
    chk("t2_grants", grants, DEPTH);
    chk("t2_count",  count_o, DEPTH);
    chk("t2_reqlow", imem_req_o, 1'b0);
    cyc_end();
    repeat (15) step(0, 32'h0, 1, 1, 1);

    // Three requests in flight at 0x10..0x18, then redirect to 0x100
    do_reset();
    step(0, 32'h0, 0, 0, 1);
    step(1, 32'h10, 0, 0, 1);
    repeat (3) step(0, 32'h0, 1, 0, 1);
    step(1, 32'h100, 1, 0, 1);
    first_pc = 32'hDEAD_BEEF; got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      cyc_begin(0, 32'h0, 1, 1, 1);
      if (inst_valid_o) begin first_pc = inst_pc_o; got = 1; end
      cyc_end();
    end
    chk("t3_first_pc", first_pc, 32'h100);

    // Redirect coinciding with a response and a pop, two requests in flight
    do_reset();
    step(0, 32'h0, 0, 0, 0);
    step(1, 32'h40, 0, 0, 0);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 1, 1, 0);
    step(0, 32'h0, 1, 0, 0);
    step(1, 32'h200, 1, 1, 1);
    cyc_begin(0, 32'h0, 0, 0, 1);
    chk("t4_count", count_o, 32'h0);
    chk("t4_drop",  dut.drop_cnt_q, 32'h1);
    cyc_end();
    first_pc = 32'hDEAD_BEEF; got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      cyc_begin(0, 32'h0, 1, 1, 1);
      if (inst_valid_o) begin first_pc = inst_pc_o; got = 1; end
      cyc_end();
    end
    chk("t4_first_pc", first_pc, 32'h200);

    // PC wrap-around past 2^32
    do_reset();
    step(0, 32'h0, 0, 0, 1);
    step(1, 32'hFFFF_FFF8, 0, 0, 1);
    foreach (pcs[i]) pcs[i] = 32'hDEAD_BEEF;
    n = 0;
    for (int k = 0; k < 30 && n < 3; k++) begin
      cyc_begin(0, 32'h0, 1, 1, 1);
      if (inst_valid_o && inst_ready_i) begin pcs[n] = inst_pc_o; n++; end
      cyc_end();
    end
    chk("t5_pc0", pcs[0], 32'hFFFF_FFF8);
    chk("t5_pc1", pcs[1], 32'hFFFF_FFFC);
    chk("t5_pc2", pcs[2], 32'h0000_0000);

    // Reset with entries buffered and requests in flight
    do_reset();
    step(0, 32'h0, 0, 0, 0);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 0, 1, 0);
    step(0, 32'h0, 0, 1, 0);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);
    cyc_begin(0, 32'h0, 0, 0, 0);
    chk("t6_count_before", count_o, 32'h2);
    cyc_end();
    do_reset();
    step(0, 32'h0, 1, 0, 1);
    cyc_begin(0, 32'h0, 1, 0, 1);
    chk("t6_refetch_req",  imem_req_o,  1'b1);
    chk("t6_refetch_addr", imem_addr_o, RESET_PC);
    cyc_end();

    // Randomised traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bit          rd;
      logic [31:0] tgt;
      if (i == 750) do_reset();
      rd  = ($urandom_range(0, 99) < 5);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2))
                                        : ($urandom & 32'hFFFF_FFFC);
      step(rd, tgt, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
